// File: rtl/data_write_buffer.sv
// Posted-store buffer between the core data port and the AXI bridge data port.
// Stores are acked after one cycle and drained in order. Loads that do not alias a buffered store bypass the queue.
module data_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_req,
    input  logic        s_wr,
    input  logic [1:0]  s_size,
    input  logic [31:0] s_addr,
    input  logic [31:0] s_wdata,
    input  logic        s_uncached,
    output logic [31:0] s_rdata,
    output logic        s_addr_ok,
    output logic        s_data_ok,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_uncached,
    input  logic [31:0] m_rdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    output logic        wb_empty
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_WAIT  = 2'd1,
        STORE_WAIT = 2'd2
    } state_t;

    state_t             state_r;
    logic [31:0]        ent_addr_r  [DEPTH];
    logic [1:0]         ent_size_r  [DEPTH];
    logic [31:0]        ent_wdata_r [DEPTH];
    logic [DEPTH-1:0]   ent_unc_r;
    logic [DEPTH-1:0]   valid_r;
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [PTR_W:0]     count_r;
    logic               store_ack_r;
    logic               drain_hold_r;

    logic               full_s;
    logic               empty_s;
    logic               hit_s;
    logic               load_ok_s;
    logic               push_s;
    logic               pop_s;
    logic               sel_load_s;
    logic               sel_store_s;

    assign full_s    = (count_r == (PTR_W+1)'(DEPTH));
    assign empty_s   = (count_r == '0);
    assign push_s    = s_req & s_wr & ~full_s & (state_r != LOAD_WAIT);
    assign pop_s     = (state_r == STORE_WAIT) & m_data_ok;
    assign load_ok_s = s_req & ~s_wr & ~hit_s & (~s_uncached | empty_s) & ~store_ack_r;
    // A drain request that has been raised but not yet accepted keeps the port until m_addr_ok.
    assign sel_load_s  = (state_r == IDLE) & ~drain_hold_r & load_ok_s;
    assign sel_store_s = (state_r == IDLE) & ~sel_load_s & ~empty_s;

    assign s_addr_ok = push_s | (sel_load_s & m_addr_ok);
    assign wb_empty  = empty_s & (state_r != STORE_WAIT);

    // Word-granular alias check against every buffered store, including the one being drained.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_r[i] && (ent_addr_r[i][31:2] == s_addr[31:2])) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Downstream request mux and core response path.
    always_comb begin
        m_req      = 1'b0;
        m_wr       = 1'b0;
        m_size     = 2'd0;
        m_addr     = 32'h0;
        m_wdata    = 32'h0;
        m_uncached = 1'b0;
        s_data_ok  = store_ack_r;
        s_rdata    = 32'h0;
        if (sel_load_s) begin
            m_req      = 1'b1;
            m_wr       = 1'b0;
            m_size     = s_size;
            m_addr     = s_addr;
            m_uncached = s_uncached;
        end else if (sel_store_s) begin
            m_req      = 1'b1;
            m_wr       = 1'b1;
            m_size     = ent_size_r[head_r];
            m_addr     = ent_addr_r[head_r];
            m_wdata    = ent_wdata_r[head_r];
            m_uncached = ent_unc_r[head_r];
        end else begin
            m_req      = 1'b0;
        end
        if (state_r == LOAD_WAIT) begin
            s_data_ok = m_data_ok;
            s_rdata   = m_rdata;
        end else begin
            s_rdata   = 32'h0;
        end
    end

    // Entry payload storage; only the valid bits need a reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            ent_addr_r[tail_r]  <= s_addr;
            ent_size_r[tail_r]  <= s_size;
            ent_wdata_r[tail_r] <= s_wdata;
        end
    end

    // Queue pointers, occupancy, store ack and the transaction state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            valid_r      <= '0;
            ent_unc_r    <= '0;
            head_r       <= '0;
            tail_r       <= '0;
            count_r      <= '0;
            store_ack_r  <= 1'b0;
            drain_hold_r <= 1'b0;
        end else begin
            store_ack_r  <= push_s;
            drain_hold_r <= sel_store_s & ~m_addr_ok;
            if (push_s) begin
                valid_r[tail_r]   <= 1'b1;
                ent_unc_r[tail_r] <= s_uncached;
                tail_r            <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= head_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
            case (state_r)
                IDLE: begin
                    if (sel_load_s && m_addr_ok) begin
                        state_r <= LOAD_WAIT;
                    end else if (sel_store_s && m_addr_ok) begin
                        state_r <= STORE_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    if (m_data_ok) begin
                        state_r <= IDLE;
                    end
                end
                STORE_WAIT: begin
                    if (m_data_ok) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_write_buffer.sv
// Scoreboard bench for data_write_buffer: expected core responses and downstream requests
// are queued by the stimulus and checked by independent monitors.
module tb_data_write_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_req, s_wr, s_uncached;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_addr_ok, s_data_ok;
    logic        m_req, m_wr, m_uncached;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_addr_ok, m_data_ok;
    logic        wb_empty;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic        unc;
    } m_exp_t;

    m_exp_t      m_q[$];
    logic [31:0] s_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd_val = 32'h0;
    logic        ds_hold = 1'b0;
    logic        resp_pend = 1'b0;

    data_write_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst(rst),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_uncached(s_uncached), .s_rdata(s_rdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_uncached(m_uncached), .m_rdata(m_rdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .wb_empty(wb_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic m_expect(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                            input logic [31:0] wdata, input logic unc);
        m_exp_t e;
        e.addr = addr; e.wr = wr; e.size = size; e.wdata = wdata; e.unc = unc;
        m_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Present one core request (called #1 after a posedge) and hold it until accepted.
    task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic unc, input logic [31:0] exp_rdata,
                         output int waited, output logic wb_at_acc);
        bit done;
        s_q.push_back(wr ? 32'h0 : exp_rdata);
        s_req = 1'b1; s_wr = wr; s_size = size; s_addr = addr;
        s_wdata = wdata; s_uncached = unc;
        waited = 0; done = 1'b0; wb_at_acc = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (s_addr_ok === 1'b1) begin
                done = 1'b1;
                wb_at_acc = wb_empty;
            end else begin
                waited++;
                if (waited > 200) begin
                    checks++; errors++;
                    $display("FAIL issue_timeout: got no s_addr_ok for addr %h expected accept", addr);
                    done = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        s_req = 1'b0; s_wr = 1'b0; s_uncached = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (!(wb_empty === 1'b1 && m_q.size() == 0 && s_q.size() == 0 && !resp_pend) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk);
        chk({name, "_drain_in_time"}, 32'(n < 200), 32'd1);
        chk({name, "_wb_empty"}, 32'(wb_empty), 32'd1);
        chk({name, "_m_q_left"}, 32'(m_q.size()), 32'd0);
        chk({name, "_s_q_left"}, 32'(s_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Downstream responder: m_data_ok one cycle after acceptance unless held off.
    initial begin : responder
        logic hs, fired;
        m_data_ok = 1'b0;
        m_rdata = 32'h0;
        forever begin
            @(negedge clk);
            hs = (m_req === 1'b1) && (m_addr_ok === 1'b1);
            fired = (m_data_ok === 1'b1) || (rst === 1'b1);
            @(posedge clk); #2;
            if (fired) resp_pend = 1'b0;
            if (hs) resp_pend = 1'b1;
            m_data_ok = resp_pend && !ds_hold;
            m_rdata = resp_pend ? rd_val : 32'h0;
        end
    end

    // Core-side monitor: store ack latency and response data in acceptance order.
    initial begin : s_monitor
        logic prev_acc;
        logic [31:0] e;
        prev_acc = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_acc) chk("store_ack_latency", 32'(s_data_ok), 32'd1);
            if (s_data_ok === 1'b1) begin
                if (s_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL s_resp_unexpected: got rdata %h expected no response", s_rdata);
                end else begin
                    e = s_q.pop_front();
                    chk("s_rdata", s_rdata, e);
                end
            end
            prev_acc = (s_req === 1'b1) && (s_wr === 1'b1) && (s_addr_ok === 1'b1);
        end
    end

    // Downstream monitor: request order/contents and stability while stalled.
    initial begin : m_monitor
        m_exp_t e;
        logic prev_stall;
        logic [31:0] prev_addr;
        prev_stall = 1'b0;
        prev_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (prev_stall && rst === 1'b0) begin
                chk("m_req_stable", 32'(m_req), 32'd1);
                chk("m_addr_stable", m_addr, prev_addr);
            end
            if (m_req === 1'b1 && m_addr_ok === 1'b1) begin
                if (m_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL m_unexpected: got addr %h expected no request", m_addr);
                end else begin
                    e = m_q.pop_front();
                    chk("m_addr", m_addr, e.addr);
                    chk("m_wr", 32'(m_wr), 32'(e.wr));
                    chk("m_size", 32'(m_size), 32'(e.size));
                    chk("m_uncached", 32'(m_uncached), 32'(e.unc));
                    if (e.wr) chk("m_wdata", m_wdata, e.wdata);
                end
            end
            prev_stall = (m_req === 1'b1) && (m_addr_ok !== 1'b1);
            prev_addr = m_addr;
        end
    end

    initial begin : stimulus
        int w;
        logic wb;
        rst = 1'b1; s_req = 1'b0; s_wr = 1'b0; s_size = 2'd0; s_addr = 32'h0;
        s_wdata = 32'h0; s_uncached = 1'b0; m_addr_ok = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_s_addr_ok", 32'(s_addr_ok), 32'd0);
        chk("rst_s_data_ok", 32'(s_data_ok), 32'd0);
        chk("rst_wb_empty", 32'(wb_empty), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Three back-to-back stores with downstream stalled, then drain in order.
        m_addr_ok = 1'b0;
        m_expect(32'h100, 1'b1, 2'd2, 32'h1111_0100, 1'b0);
        m_expect(32'h104, 1'b1, 2'd2, 32'h2222_0104, 1'b0);
        m_expect(32'h108, 1'b1, 2'd2, 32'h3333_0108, 1'b0);
        issue(1'b1, 2'd2, 32'h100, 32'h1111_0100, 1'b0, 32'h0, w, wb); chk("t1_st0_wait", 32'(w), 32'd0);
        issue(1'b1, 2'd2, 32'h104, 32'h2222_0104, 1'b0, 32'h0, w, wb); chk("t1_st1_wait", 32'(w), 32'd0);
        issue(1'b1, 2'd2, 32'h108, 32'h3333_0108, 1'b0, 32'h0, w, wb); chk("t1_st2_wait", 32'(w), 32'd0);
        @(negedge clk);
        chk("t1_wb_busy", 32'(wb_empty), 32'd0);
        @(posedge clk); #1;
        m_addr_ok = 1'b1;
        wait_empty("t1");

        // Fill all four entries, fifth store refused until the cycle after the first pop.
        m_addr_ok = 1'b0;
        for (int i = 0; i < 5; i++) m_expect(32'h1000 + 32'(i * 4), 1'b1, 2'd2, 32'hA000_0000 + 32'(i), 1'b0);
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 2'd2, 32'h1000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0, 32'h0, w, wb);
            chk("t2_fill_wait", 32'(w), 32'd0);
        end
        fork
            issue(1'b1, 2'd2, 32'h1010, 32'hA000_0004, 1'b0, 32'h0, w, wb);
            begin cyc(3); m_addr_ok = 1'b1; end
        join
        chk("t2_full_wait", 32'(w), 32'd5);
        wait_empty("t2");

        // Non-aliasing cached load overtakes a buffered store.
        m_addr_ok = 1'b1; ds_hold = 1'b1; rd_val = 32'h1234_5678;
        m_expect(32'h700, 1'b1, 2'd2, 32'h0000_0700, 1'b0);
        m_expect(32'h300, 1'b0, 2'd2, 32'h0, 1'b0);
        m_expect(32'h200, 1'b1, 2'd2, 32'hDEAD_BEEF, 1'b0);
        issue(1'b1, 2'd2, 32'h700, 32'h0000_0700, 1'b0, 32'h0, w, wb);
        issue(1'b1, 2'd2, 32'h200, 32'hDEAD_BEEF, 1'b0, 32'h0, w, wb);
        chk("t3_store_wait", 32'(w), 32'd0);
        fork
            issue(1'b0, 2'd2, 32'h300, 32'h0, 1'b0, 32'h1234_5678, w, wb);
            begin cyc(3); ds_hold = 1'b0; end
        join
        chk("t3_load_wait", 32'(w), 32'd4);
        wait_empty("t3");

        // Load aliasing a buffered byte store waits for that store to complete.
        ds_hold = 1'b1; rd_val = 32'hCAFE_F00D;
        m_expect(32'h500, 1'b1, 2'd2, 32'h0000_0500, 1'b0);
        m_expect(32'h203, 1'b1, 2'd0, 32'hAB00_0000, 1'b0);
        m_expect(32'h200, 1'b0, 2'd2, 32'h0, 1'b0);
        issue(1'b1, 2'd2, 32'h500, 32'h0000_0500, 1'b0, 32'h0, w, wb);
        issue(1'b1, 2'd0, 32'h203, 32'hAB00_0000, 1'b0, 32'h0, w, wb);
        fork
            issue(1'b0, 2'd2, 32'h200, 32'h0, 1'b0, 32'hCAFE_F00D, w, wb);
            begin cyc(3); ds_hold = 1'b0; end
        join
        chk("t4_alias_wait", 32'(w), 32'd6);
        wait_empty("t4");

        // Uncached load waits for the buffer to drain completely.
        ds_hold = 1'b1; rd_val = 32'h55AA_00FF;
        m_expect(32'h600, 1'b1, 2'd2, 32'h0000_0600, 1'b0);
        m_expect(32'h400, 1'b1, 2'd2, 32'h0000_0400, 1'b0);
        m_expect(32'hBFD0_F000, 1'b0, 2'd2, 32'h0, 1'b1);
        issue(1'b1, 2'd2, 32'h600, 32'h0000_0600, 1'b0, 32'h0, w, wb);
        issue(1'b1, 2'd2, 32'h400, 32'h0000_0400, 1'b0, 32'h0, w, wb);
        fork
            issue(1'b0, 2'd2, 32'hBFD0_F000, 32'h0, 1'b1, 32'h55AA_00FF, w, wb);
            begin cyc(3); ds_hold = 1'b0; end
        join
        chk("t5_unc_wait", 32'(w), 32'd6);
        chk("t5_unc_wb_empty", 32'(wb), 32'd1);
        wait_empty("t5");

        // Reset with two stores buffered and one in STORE_WAIT discards everything.
        ds_hold = 1'b1; rd_val = 32'h600D_F00D;
        m_expect(32'h800, 1'b1, 2'd2, 32'h0000_0800, 1'b0);
        issue(1'b1, 2'd2, 32'h800, 32'h0000_0800, 1'b0, 32'h0, w, wb);
        issue(1'b1, 2'd2, 32'h804, 32'h0000_0804, 1'b0, 32'h0, w, wb);
        @(negedge clk);
        chk("t6_pre_rst_wb_busy", 32'(wb_empty), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ds_hold = 1'b0;
        @(negedge clk);
        chk("t6_rst_wb_empty", 32'(wb_empty), 32'd1);
        chk("t6_rst_m_req", 32'(m_req), 32'd0);
        chk("t6_rst_s_data_ok", 32'(s_data_ok), 32'd0);
        @(posedge clk); #1;
        m_expect(32'h804, 1'b0, 2'd2, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 32'h804, 32'h0, 1'b0, 32'h600D_F00D, w, wb);
        chk("t6_load_wait", 32'(w), 32'd0);
        wait_empty("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
